// File: rtl/tri_pkg.sv
// Shared types and defaults for the triangle-wave burst controller.
// Holds the FSM state type, default widths and command reject rules.
package tri_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    localparam int TRI_DW = 9;
    localparam int TRI_SW = 4;
    localparam int TRI_CW = 8;

    // A command with any of these fields at zero would never produce a period.
    localparam bit REJECT_ZERO_PEAK   = 1'b1;
    localparam bit REJECT_ZERO_STEP   = 1'b1;
    localparam bit REJECT_ZERO_CYCLES = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tri_step_alu.sv
// Saturating step arithmetic: add-to-peak when rising, subtract-to-zero when falling.
// Works in DW+1 bits so peak=2^DW-1 with the largest step cannot wrap.
module tri_step_alu
    import tri_pkg::*;
#(
    parameter int DW = TRI_DW,
    parameter int SW = TRI_SW
) (
    input  logic [DW-1:0] d,
    input  logic [SW-1:0] step,
    input  logic [DW-1:0] peak,
    input  logic          dir,
    output logic [DW-1:0] next,
    output logic          hit_limit
);

    logic [DW:0] d_ext;
    logic [DW:0] step_ext;
    logic [DW:0] peak_ext;
    logic [DW:0] sum;

    assign d_ext    = {1'b0, d};
    assign step_ext = {{(DW + 1 - SW){1'b0}}, step};
    assign peak_ext = {1'b0, peak};
    assign sum      = d_ext + step_ext;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next      = '0;
        hit_limit = 1'b0;
        if (dir == DIR_UP) begin
            if (sum >= peak_ext) begin
                next      = peak;
                hit_limit = 1'b1;
            end else begin
                next = sum[DW-1:0];
            end
        end else begin
            if (d_ext <= step_ext) begin
                next      = '0;
                hit_limit = 1'b1;
            end else begin
                next = d - step_ext[DW-1:0];
            end
        end
    end

endmodule

// File: rtl/tri_burst_ctrl.sv
// Burst sequencer for the triangle datapath: accepts peak/step/period commands,
// walks the output up and down for the requested periods, and reports done/err/aborted.
module tri_burst_ctrl
    import tri_pkg::*;
#(
    parameter int DW = TRI_DW,
    parameter int SW = TRI_SW,
    parameter int CW = TRI_CW
) (
    input  logic          clk,
    input  logic          res,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_peak,
    input  logic [SW-1:0] cmd_step,
    input  logic [CW-1:0] cmd_cycles,
    input  logic          abort,
    output logic [DW-1:0] d_out,
    output logic          busy,
    output logic [CW-1:0] cyc_left,
    output logic          done,
    output logic          err,
    output logic          aborted
);

    state_t        state;
    logic [DW-1:0] peak_q;
    logic [SW-1:0] step_q;
    logic [DW-1:0] alu_next;
    logic          alu_hit;
    logic          reject;

    assign cmd_ready = (state == IDLE) && !abort;
    assign busy      = (state != IDLE);

    assign reject = (REJECT_ZERO_PEAK   && (cmd_peak   == '0)) ||
                    (REJECT_ZERO_STEP   && (cmd_step   == '0)) ||
                    (REJECT_ZERO_CYCLES && (cmd_cycles == '0));

    tri_step_alu #(
        .DW(DW),
        .SW(SW)
    ) u_alu (
        .d        (d_out),
        .step     (step_q),
        .peak     (peak_q),
        .dir      ((state == RISE) ? DIR_UP : DIR_DOWN),
        .next     (alu_next),
        .hit_limit(alu_hit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            state    <= IDLE;
            d_out    <= '0;
            cyc_left <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            aborted  <= 1'b0;
            // NOTE: the latched command is cleared too, so nothing from a killed burst survives reset.
            peak_q   <= '0;
            step_q   <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            peak_q   <= cmd_peak;
                            step_q   <= cmd_step;
                            cyc_left <= cmd_cycles;
                            d_out    <= '0;
                            state    <= RISE;
                        end
                    end
                end
                RISE, FALL: begin
                    // Abort outranks normal completion, even on the final edge of a burst.
                    if (abort) begin
                        d_out    <= '0;
                        cyc_left <= '0;
                        aborted  <= 1'b1;
                        state    <= IDLE;
                    end else if (state == RISE) begin
                        d_out <= alu_next;
                        if (alu_hit) begin
                            state <= FALL;
                        end
                    end else begin
                        d_out <= alu_next;
                        if (alu_hit) begin
                            if (cyc_left == CW'(1)) begin
                                cyc_left <= '0;
                                done     <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                cyc_left <= cyc_left - 1'b1;
                                state    <= RISE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
